// File: rtl/bnn_pkg.sv
// Shared constants and types for the array result-capture path.
package bnn_pkg;
  localparam int LANES  = 32;
  localparam int DW     = 16;
  localparam int AW     = 11;
  localparam int BW     = 6;
  localparam int PAIR_W = $clog2(LANES / 2);

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic [AW-1:0]     row;
    logic [PAIR_W-1:0] pair;
  } rd_req_t;
endpackage

// File: rtl/output_lane_mem.sv
// One lane of result storage: capture counter plus a read-first simple dual-port RAM.
module output_lane_mem
  import bnn_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 11,
  parameter int BW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          armed,
  input  logic [AW-1:0] base,
  input  logic [BW-1:0] batch,
  input  logic          wr_vld,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_row,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          excess
);
  logic [DW-1:0] mem [2**AW];
  logic [BW-1:0] cnt;
  logic          accept;

  // cnt never passes batch, so equality is the quota test
  assign full   = (cnt == batch);
  assign accept = armed && wr_vld && !full;
  assign excess = wr_vld && (!armed || full);

  always_ff @(posedge clk) begin
    if (reset)       cnt <= '0;
    else if (clr)    cnt <= '0;
    else if (accept) cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (accept) mem[base + AW'(cnt)] <= wr_data;
    if (rd_en)  rd_data <= mem[rd_row];
  end
endmodule

// File: rtl/output_collector.sv
// Captures skewed per-lane result streams into lane RAMs and serves them on a 2-cycle host read port.
module output_collector
  import bnn_pkg::*;
#(
  parameter int LANES = bnn_pkg::LANES,
  parameter int DW    = bnn_pkg::DW,
  parameter int AW    = bnn_pkg::AW,
  parameter int BW    = bnn_pkg::BW
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [AW-1:0]       addr_start,
  input  logic [BW-1:0]       batch,
  input  logic [LANES*DW-1:0] activation_out,
  input  logic [LANES-1:0]    activation_out_valid,
  output logic                busy,
  output logic                done,
  output logic                err,
  input  logic                s_en,
  input  logic [16:0]         s_addr,
  output logic [31:0]         s_dout
);
  localparam int PW        = $clog2(LANES / 2);
  localparam int RD_STAGES = 1;

  state_t                        state, state_nx;
  logic                          done_nx, clr;
  logic [AW-1:0]                 base_q;
  logic [BW-1:0]                 batch_q;
  logic [LANES-1:0]              full, excess;
  logic [LANES-1:0][DW-1:0]      lane_rd;
  logic [LANES/2-1:0][2*DW-1:0]  pair_rd;
  logic [RD_STAGES:0]            vld_pipe;
  rd_req_t                       req_q;
  logic [PW-1:0]                 pair_q;
  logic                          addr_unused;

  assign busy        = (state == BUSY);
  assign pair_rd     = lane_rd;
  assign addr_unused = ^s_addr[1:0];

  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    clr      = 1'b0;
    case (state)
      IDLE: if (start) begin
        clr = 1'b1;
        if (batch != '0) state_nx = BUSY;
        else             done_nx  = 1'b1;
      end
      BUSY: if (&full) begin
        state_nx = IDLE;
        done_nx  = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      done    <= 1'b0;
      err     <= 1'b0;
      base_q  <= '0;
      batch_q <= '0;
    end else begin
      state <= state_nx;
      done  <= done_nx;
      err   <= (err & ~clr) | (|excess);
      if (clr) begin
        base_q  <= addr_start;
        batch_q <= batch;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    output_lane_mem #(.DW(DW), .AW(AW), .BW(BW)) u_lane (
      .clk     (clk),
      .reset   (reset),
      .clr     (clr),
      .armed   (busy),
      .base    (base_q),
      .batch   (batch_q),
      .wr_vld  (activation_out_valid[i]),
      .wr_data (activation_out[i*DW +: DW]),
      .rd_en   (vld_pipe[0]),
      .rd_row  (req_q.row),
      .rd_data (lane_rd[i]),
      .full    (full[i]),
      .excess  (excess[i])
    );
  end

  // stage 0: request captured, stage 1: lane RAMs read, then the pair mux lands in s_dout
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      s_dout   <= '0;
    end else begin
      vld_pipe <= {vld_pipe[RD_STAGES-1:0], s_en};
      if (vld_pipe[RD_STAGES]) s_dout <= pair_rd[pair_q];
    end
  end

  always_ff @(posedge clk) begin
    if (s_en) req_q <= '{row: s_addr[6 +: AW], pair: s_addr[2 +: PW]};
    pair_q <= req_q.pair;
  end
endmodule

// File: tb/tb_output_collector.sv
// Randomized bench for output_collector against an array/queue level reference model.
module tb_output_collector;
  import bnn_pkg::*;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                start = 1'b0;
  logic [AW-1:0]       addr_start = '0;
  logic [BW-1:0]       batch = '0;
  logic [LANES*DW-1:0] act = '0;
  logic [LANES-1:0]    act_v = '0;
  logic                busy, done, err;
  logic                s_en = 1'b0;
  logic [16:0]         s_addr = '0;
  logic [31:0]         s_dout;

  int n_chk = 0;
  int n_fail = 0;

  output_collector dut (
    .clk(clk), .reset(reset), .start(start), .addr_start(addr_start), .batch(batch),
    .activation_out(act), .activation_out_valid(act_v),
    .busy(busy), .done(done), .err(err),
    .s_en(s_en), .s_addr(s_addr), .s_dout(s_dout)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [15:0] mm [LANES][2048];
  bit          mk [LANES][2048];
  int          m_cnt [LANES];
  int          m_batch, m_base;
  bit          m_busy, m_done, m_err;
  bit          p1_v, p2_v, p2_k, m_dout_k;
  int          p1_row, p1_pair;
  logic [31:0] p2_d, m_dout;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit full_all, exc;
    int row;
    if (reset) begin
      m_busy = 0; m_done = 0; m_err = 0; p1_v = 0; p2_v = 0;
      m_dout = '0; m_dout_k = 1;
      return;
    end
    if (p2_v) begin m_dout = p2_d; m_dout_k = p2_k; end
    p2_v = p1_v;
    if (p1_v) begin
      p2_d = {mm[2*p1_pair+1][p1_row], mm[2*p1_pair][p1_row]};
      p2_k = mk[2*p1_pair+1][p1_row] && mk[2*p1_pair][p1_row];
    end
    p1_v = s_en; p1_row = int'(s_addr[16:6]); p1_pair = int'(s_addr[5:2]);
    full_all = 1;
    for (int i = 0; i < LANES; i++) if (m_cnt[i] != m_batch) full_all = 0;
    exc = 0; m_done = 0;
    for (int i = 0; i < LANES; i++) begin
      if (act_v[i]) begin
        if (m_busy && m_cnt[i] < m_batch) begin
          row = (m_base + m_cnt[i]) % 2048;
          mm[i][row] = act[i*DW +: DW];
          mk[i][row] = 1;
          m_cnt[i]++;
        end else exc = 1;
      end
    end
    if (!m_busy && start) begin
      m_err = 0; m_base = int'(addr_start); m_batch = int'(batch);
      for (int i = 0; i < LANES; i++) m_cnt[i] = 0;
      if (batch != 0) m_busy = 1; else m_done = 1;
    end else if (m_busy && full_all) begin
      m_busy = 0; m_done = 1;
    end
    if (exc) m_err = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("err", err, m_err);
    if (m_dout_k) chk("s_dout", s_dout, m_dout);
  endtask

  task automatic rand_act();
    for (int i = 0; i < LANES; i++) act[i*DW +: DW] = 16'($urandom);
  endtask

  function automatic logic [16:0] haddr(input int row, input int pair);
    return {11'(row), 4'(pair), 2'b00};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int dones, cyc;
    logic [15:0] saved, w2, w3;
    logic [10:0] row;

    repeat (2) tick();
    chk("rst_busy", busy, 0);
    chk("rst_sdout", s_dout, 0);
    reset = 0; tick();

    // basic run
    start = 1; addr_start = 11'd5; batch = 6'd3; tick(); start = 0;
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < LANES; i++) act[i*DW +: DW] = 16'(16'h100 * i + n);
      act_v = '1; tick();
    end
    act_v = '0;
    chk("basic_busy_w3", busy, 1);
    tick(); chk("basic_done", done, 1); chk("basic_idle", busy, 0);
    tick(); chk("basic_done_len", done, 0);
    s_en = 1; s_addr = haddr(6, 1); tick(); s_en = 0; tick(); tick();
    chk("basic_rd", s_dout, 32'h0301_0201);

    // skewed lanes, with an ignored start while busy
    start = 1; addr_start = 11'd100; batch = 6'd2; tick(); start = 0;
    dones = 0;
    for (int c = 0; c < 36; c++) begin
      rand_act();
      for (int i = 0; i < LANES; i++) act_v[i] = (c >= i && c < i + 2);
      if (c == 10) begin start = 1; batch = 6'd5; end else start = 0;
      tick();
      dones += int'(done);
      if (c <= 32) chk("skew_busy", busy, 1);
    end
    act_v = '0; start = 0;
    chk("skew_done_once", dones, 1);
    chk("skew_err", err, 0);

    // wrap past the top row
    start = 1; addr_start = 11'd2046; batch = 6'd4; tick(); start = 0;
    for (int n = 0; n < 4; n++) begin
      rand_act(); act[DW-1:0] = 16'(n + 1); act_v = '1; tick();
    end
    act_v = '0; tick();
    for (int j = 0; j < 6; j++) begin
      if (j < 4) begin s_en = 1; s_addr = haddr((2046 + j) % 2048, 0); end
      else s_en = 0;
      tick();
      if (j >= 2) chk("wrap_rd", 32'(s_dout[15:0]), 32'(j - 1));
    end

    // idle valid, then excess valid on lane 3
    act_v[7] = 1; rand_act(); tick(); act_v = '0;
    chk("idle_err", err, 1);
    start = 1; addr_start = 11'd300; batch = 6'd4; tick(); start = 0;
    chk("start_clr_err", err, 0);
    saved = '0;
    for (int n = 0; n < 4; n++) begin
      rand_act(); saved = act[3*DW +: DW]; act_v = '1; tick();
    end
    act_v = '0; act_v[3] = 1; rand_act(); tick(); act_v = '0;
    chk("excess_err", err, 1);
    chk("excess_done", done, 1);
    s_en = 1; s_addr = haddr(303, 1); tick(); s_en = 0; tick(); tick();
    chk("excess_keep", 32'(s_dout[31:16]), 32'(saved));

    // reset mid-run
    start = 1; addr_start = 11'd400; batch = 6'd3; tick(); start = 0;
    rand_act(); act_v = '1; s_en = 1; s_addr = haddr(6, 1); tick();
    act_v = '0; s_en = 0; tick(); tick();
    reset = 1; tick();
    chk("mrst_busy", busy, 0);
    chk("mrst_err", err, 0);
    chk("mrst_sdout", s_dout, 0);
    reset = 0; tick(); chk("mrst_no_done", done, 0);
    start = 1; addr_start = 11'd500; batch = 6'd1; tick(); start = 0;
    rand_act(); act_v = '1; tick(); act_v = '0;
    tick(); chk("post_rst_done", done, 1);

    // same-row read during write returns old data
    start = 1; addr_start = 11'd6; batch = 6'd1; tick(); start = 0;
    s_en = 1; s_addr = haddr(6, 1); tick();
    s_en = 0; rand_act(); w2 = act[2*DW +: DW]; w3 = act[3*DW +: DW]; act_v = '1; tick();
    act_v = '0; tick();
    chk("collide_old", s_dout, 32'h0301_0201);
    s_en = 1; tick(); s_en = 0; tick(); tick();
    chk("collide_new", s_dout, {w3, w2});

    // batch of zero
    start = 1; batch = 6'd0; tick(); start = 0;
    chk("b0_done", done, 1); chk("b0_busy", busy, 0);
    tick(); chk("b0_done_len", done, 0); chk("b0_busy2", busy, 0);

    // random runs with concurrent host reads
    for (int r = 0; r < 8; r++) begin
      start = 1; addr_start = 11'($urandom); batch = 6'($urandom_range(1, 5)); tick(); start = 0;
      cyc = 0;
      while (m_busy && cyc < 300) begin
        rand_act(); act_v = $urandom;
        row = addr_start + 11'($urandom_range(0, 5));
        s_en = 1'($urandom); s_addr = {row, 4'($urandom), 2'b00};
        tick(); cyc++;
      end
      act_v = '0; s_en = 0;
      chk("rnd_idle", busy, 0);
      repeat (3) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
